// File: rtl/twiddle_seq_ctrl_pkg.sv
// Shared FFT constants and sequencer state encoding.
// Stage offsets and frame length derive from the FFT size.
package twiddle_seq_ctrl_pkg;

  localparam int N_POINTS   = 128;
  localparam int PAR        = 4;
  localparam int FRAME_LEN  = N_POINTS / PAR;
  localparam int ADDR_W     = $clog2(FRAME_LEN);
  localparam int NUM_STAGES = $clog2(N_POINTS);
  localparam int COEFF_W    = 11;
  localparam int STAGE_LAT  = 34;
  localparam int CNT_W      = 8;

  function automatic int total_cycles(int lat);
    return (NUM_STAGES - 1) * lat + FRAME_LEN;
  endfunction

  localparam int TOTAL = total_cycles(STAGE_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/twiddle_seq_ctrl_if.sv
// Handshake and ROM-port bundle of the twiddle sequencer.
// master drives start/hold; slave is the sequencer.
interface twiddle_seq_ctrl_if;
  import twiddle_seq_ctrl_pkg::*;

  logic                         start;
  logic                         hold;
  logic                         ready;
  logic                         busy;
  logic [NUM_STAGES-1:0]        coeff_rd_en;
  logic [NUM_STAGES*ADDR_W-1:0] coeff_addr;
  logic [NUM_STAGES-1:0]        coeff_valid;
  logic                         frame_done;
  logic                         overrun;

  modport master (
    output start, hold,
    input  ready, busy, coeff_rd_en, coeff_addr,
    input  coeff_valid, frame_done, overrun
  );

  modport slave (
    input  start, hold,
    output ready, busy, coeff_rd_en, coeff_addr,
    output coeff_valid, frame_done, overrun
  );

endinterface

// File: rtl/twiddle_stage_addr.sv
// Per-stage ROM window decode: registered read enable, address, valid.
// Fed with next-cycle counter/run so outputs align with the counter.
module twiddle_stage_addr
  import twiddle_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              run,
  input  logic              hold,
  input  logic [CNT_W-1:0]  offset,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              valid
);

  logic [CNT_W-1:0] rel;
  logic             act;

  always_comb begin
    rel = cnt - offset;
    act = run && (cnt >= offset) && (rel < CNT_W'(FRAME_LEN));
  end

  // a held cycle re-presents the last address with no read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en <= 1'b0;
      addr  <= '0;
      valid <= 1'b0;
    end else begin
      rd_en <= act && !hold;
      addr  <= act ? rel[ADDR_W-1:0] : '0;
      valid <= rd_en;
    end
  end

endmodule

// File: rtl/twiddle_seq_ctrl.sv
// Frame-aligned, stallable twiddle ROM sequencer for the N=128 FFT.
// Holds the frame FSM and counter; stages decode their own windows.
module twiddle_seq_ctrl
  import twiddle_seq_ctrl_pkg::*;
#(
  parameter int STAGE_LAT = twiddle_seq_ctrl_pkg::STAGE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  twiddle_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(total_cycles(STAGE_LAT) - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             ovr_nxt;
  logic             stall;
  logic             run_nxt;

  logic [NUM_STAGES-1:0] rd_en;
  logic [NUM_STAGES-1:0] valid;
  logic [ADDR_W-1:0]     addr_a [NUM_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bus.frame_done <= done_nxt;
      bus.overrun    <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ovr_nxt   = 1'b0;
    stall     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      (state == RUN): begin
        ovr_nxt = bus.start;
        stall   = bus.hold;
        if (!bus.hold) begin
          if (cnt == LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  assign run_nxt = (state_nxt == RUN);

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    twiddle_stage_addr u_stage (
      .clk    (clk),
      .rst    (rst),
      .cnt    (cnt_nxt),
      .run    (run_nxt),
      .hold   (stall),
      .offset (CNT_W'(s * STAGE_LAT)),
      .rd_en  (rd_en[s]),
      .addr   (addr_a[s]),
      .valid  (valid[s])
    );
    assign bus.coeff_addr[s*ADDR_W +: ADDR_W] = addr_a[s];
  end

  assign bus.coeff_rd_en = rd_en;
  assign bus.coeff_valid = valid;
  assign bus.ready       = (state == IDLE);
  assign bus.busy        = (state == RUN);

endmodule

// File: tb/tb_twiddle_seq_ctrl.sv
// Scoreboard bench: two sequencers (lat 34 and 16) against a frame model.
// Directed frame scenarios followed by random start/hold/rst traffic.
module tb_twiddle_seq_ctrl;
  import twiddle_seq_ctrl_pkg::*;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        done;
    logic        ovr;
    logic [6:0]  rd;
    logic [6:0]  val;
    logic [34:0] addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  obs_t q34[$];
  obs_t q16[$];
  bit   m_run [2];
  int   m_pos [2];
  obs_t m_out [2];

  always #5 clk = ~clk;

  twiddle_seq_ctrl_if if34 ();
  twiddle_seq_ctrl_if if16 ();

  assign if34.start = start;
  assign if34.hold  = hold;
  assign if16.start = start;
  assign if16.hold  = hold;

  twiddle_seq_ctrl #(.STAGE_LAT(34)) dut34 (
    .clk (clk),
    .rst (rst),
    .bus (if34)
  );

  twiddle_seq_ctrl #(.STAGE_LAT(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  // frame model: pos counts un-held cycles since the accepted start
  function automatic obs_t model_step(int d, int lat, bit s, bit h, bit r);
    obs_t o;
    bit   adv;
    int   off;
    o = '0;
    if (r) begin
      m_run[d] = 0;
      m_pos[d] = 0;
      o.ready  = 1'b1;
      m_out[d] = o;
      return o;
    end
    o.val = m_out[d].rd;
    adv = 0;
    if (!m_run[d]) begin
      if (s) begin
        m_run[d] = 1;
        m_pos[d] = 0;
        adv = 1;
      end
    end else begin
      o.ovr = s;
      if (!h) begin
        adv = 1;
        if (m_pos[d] == 6 * lat + 32 - 1) begin
          m_run[d] = 0;
          o.done = 1'b1;
        end else begin
          m_pos[d]++;
        end
      end
    end
    o.ready = !m_run[d];
    o.busy  = m_run[d];
    for (int k = 0; k < 7; k++) begin
      off = k * lat;
      if (m_run[d] && m_pos[d] >= off && m_pos[d] < off + 32) begin
        o.rd[k] = adv;
        o.addr[k*5 +: 5] = 5'(m_pos[d] - off);
      end
    end
    m_out[d] = o;
    return o;
  endfunction

  always @(posedge clk) begin
    q34.push_back(model_step(0, 34, start, hold, rst));
    q16.push_back(model_step(1, 16, start, hold, rst));
  end

  function automatic obs_t observe(int d);
    obs_t o;
    if (d == 0) begin
      o.ready = if34.ready;       o.busy = if34.busy;
      o.done  = if34.frame_done;  o.ovr  = if34.overrun;
      o.rd    = if34.coeff_rd_en; o.val  = if34.coeff_valid;
      o.addr  = if34.coeff_addr;
    end else begin
      o.ready = if16.ready;       o.busy = if16.busy;
      o.done  = if16.frame_done;  o.ovr  = if16.overrun;
      o.rd    = if16.coeff_rd_en; o.val  = if16.coeff_valid;
      o.addr  = if16.coeff_addr;
    end
    return o;
  endfunction

  task automatic score(string nm, int d, ref obs_t q[$]);
    obs_t e, a;
    vectors++;
    a = observe(d);
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: output %h with no expected entry", nm, a);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    score("sb34", 0, q34);
    score("sb16", 1, q16);
  end

  task automatic check(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(bit s, bit h, bit r);
    start = s;
    hold  = h;
    rst   = r;
    @(negedge clk);
  endtask

  // one frame from IDLE; optional 3-cycle hold, overrun start, chained start
  task automatic run_frame(int hold_at, int ov_at, bit chain,
                           output int done_n);
    int n;
    bit h;
    done_n = -1;
    cyc(1, 0, 0);
    n = 1;
    while (n < 400 && done_n < 0) begin
      if (if34.frame_done) done_n = n;
      if (hold_at > 0 && n == hold_at + 3) begin
        check("hold_addr", int'(if34.coeff_addr[4:0]), 10);
        check("hold_rden", int'(if34.coeff_rd_en[0]), 0);
      end
      if (hold_at > 0 && n == hold_at + 4) begin
        check("resume_addr", int'(if34.coeff_addr[4:0]), 11);
        check("resume_rden", int'(if34.coeff_rd_en[0]), 1);
      end
      if (ov_at > 0 && n == ov_at + 1) begin
        check("overrun", int'(if34.overrun), 1);
        check("ready_run", int'(if34.ready), 0);
      end
      h = hold_at > 0 && n >= hold_at && n < hold_at + 3;
      if (done_n >= 0 && chain) cyc(1, 0, 0);
      else if (done_n < 0) cyc(n == ov_at, h, 0);
      n++;
    end
    if (done_n < 0) check("frame_timeout", 0, 1);
  endtask

  initial begin
    int f34, f16, s6, ov16, a0, n, dn;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("rst_ready", int'(if34.ready), 1);
    check("rst_busy", int'(if34.busy), 0);
    cyc(0, 0, 0);

    // nominal frame on both latencies
    f34 = -1; f16 = -1; s6 = -1; ov16 = -1; a0 = -1;
    cyc(1, 0, 0);
    n = 1;
    while (n < 400 && f34 < 0) begin
      if (if34.frame_done && f34 < 0) f34 = n;
      if (if16.frame_done && f16 < 0) f16 = n;
      if (if34.coeff_rd_en[6] && s6 < 0) s6 = n;
      if (if16.coeff_rd_en[1] && ov16 < 0) begin
        ov16 = n;
        a0 = int'(if16.coeff_addr[4:0]);
      end
      cyc(0, 0, 0);
      n++;
    end
    check("done34", f34, 237);
    check("stage6_first", s6, 205);
    check("done16", f16, 129);
    check("overlap16", ov16, 17);
    check("overlap_addr0", a0, 16);
    repeat (5) cyc(0, 0, 0);

    run_frame(11, 0, 0, dn);
    check("done_hold", dn, 240);
    repeat (5) cyc(0, 0, 0);

    run_frame(0, 101, 0, dn);
    check("done_ovr", dn, 237);
    repeat (5) cyc(0, 0, 0);

    run_frame(0, 0, 1, dn);
    check("chain_addr", int'(if34.coeff_addr[4:0]), 0);
    check("chain_rden", int'(if34.coeff_rd_en[0]), 1);
    check("chain_ovr", int'(if34.overrun), 0);
    repeat (250) cyc(0, 0, 0);

    // reset mid-frame
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("abort_rden", int'(if34.coeff_rd_en), 0);
    check("abort_busy", int'(if34.busy), 0);
    check("abort_ready", int'(if34.ready), 1);
    f34 = 0;
    repeat (300) begin
      if (if34.frame_done) f34++;
      cyc(0, 0, 0);
    end
    check("abort_nodone", f34, 0);

    repeat (4000) begin
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 999) == 0);
    end
    repeat (3) cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
